// File: rtl/templatized_alu_pkg.sv
// Shared types for the ALU issue controller: op codes, unit one-hot select,
// FSM state encoding and op-to-unit decode helpers.
package templatized_alu_pkg;

    localparam int UNIT_CNT = 3;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MUL = 3'b010,
        OP_AND = 3'b011,
        OP_OR  = 3'b100,
        OP_XOR = 3'b101,
        OP_SHL = 3'b110,
        OP_ILL = 3'b111
    } alu_op_e;

    // Bit 2 selects unit0, bit 0 selects unit2.
    typedef logic [UNIT_CNT-1:0] unit_sel_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } alu_state_e;

    function automatic unit_sel_t alu_op_to_en(input logic [2:0] op);
        unit_sel_t en;
        case (alu_op_e'(op))
            OP_ADD, OP_SUB:                 en = 3'b100;
            OP_MUL:                         en = 3'b010;
            OP_AND, OP_OR, OP_XOR, OP_SHL:  en = 3'b001;
            default:                        en = 3'b000;
        endcase
        return en;
    endfunction

    function automatic logic alu_op_legal(input logic [2:0] op);
        return alu_op_to_en(op) != '0;
    endfunction

endpackage

// File: rtl/templatized_alu_issue_ctrl.sv
// Issues one op at a time to one of three ALU units, waits for its done (or a
// timeout) and returns the result on a valid/ready response channel.
module templatized_alu_issue_ctrl
    import templatized_alu_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int TMO_W    = 8,
    parameter int MAX_WAIT = 200
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    input  logic [2:0]                   req_op_i,
    input  logic [DATA_W-1:0]            req_a_i,
    input  logic [DATA_W-1:0]            req_b_i,
    output logic [UNIT_CNT-1:0]          unit_en_o,
    output logic [2:0]                   unit_op_o,
    output logic [DATA_W-1:0]            unit_a_o,
    output logic [DATA_W-1:0]            unit_b_o,
    input  logic [UNIT_CNT-1:0]          unit_done_i,
    input  logic [UNIT_CNT*DATA_W-1:0]   unit_result_i,
    output logic                         resp_valid_o,
    input  logic                         resp_ready_i,
    output logic [DATA_W-1:0]            resp_result_o,
    output logic                         resp_err_o,
    output logic                         busy_o
);

    localparam logic [TMO_W-1:0] MAX_WAIT_C = TMO_W'(MAX_WAIT);

    alu_state_e          state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    unit_sel_t           en_q, en_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                err_q, err_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;

    logic                sel_done;
    logic [DATA_W-1:0]   sel_result;
    logic [TMO_W-1:0]    tmo_inc;

    always_comb begin
        sel_result = '0;
        for (int k = 0; k < UNIT_CNT; k++) begin
            if (en_q[k]) sel_result = unit_result_i[k*DATA_W +: DATA_W];
        end
    end

    // Done bits of units that were not enabled are masked off here.
    assign sel_done = |(unit_done_i & en_q);
    assign tmo_inc  = tmo_q + TMO_W'(1);

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        en_d     = en_q;
        result_d = result_q;
        err_d    = err_q;
        tmo_d    = tmo_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    op_d     = req_op_i;
                    a_d      = req_a_i;
                    b_d      = req_b_i;
                    en_d     = alu_op_to_en(req_op_i);
                    tmo_d    = '0;
                    result_d = '0;
                    if (alu_op_legal(req_op_i)) begin
                        err_d   = 1'b0;
                        state_d = ST_EXEC;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_EXEC: begin
                // Done takes priority over a timeout expiring in the same cycle.
                if (sel_done) begin
                    result_d = sel_result;
                    err_d    = 1'b0;
                    state_d  = ST_RESP;
                end else begin
                    tmo_d = tmo_inc;
                    if (tmo_inc == MAX_WAIT_C) begin
                        result_d = '0;
                        err_d    = 1'b1;
                        state_d  = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (resp_ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            en_q     <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            en_q     <= en_d;
            result_q <= result_d;
            err_q    <= err_d;
            tmo_q    <= tmo_d;
        end
    end

    assign req_ready_o   = (state_q == ST_IDLE);
    assign resp_valid_o  = (state_q == ST_RESP);
    assign busy_o        = (state_q != ST_IDLE);
    assign unit_en_o     = (state_q == ST_EXEC) ? en_q : '0;
    assign unit_op_o     = op_q;
    assign unit_a_o      = a_q;
    assign unit_b_o      = b_q;
    assign resp_result_o = result_q;
    assign resp_err_o    = err_q;

endmodule

// File: tb/tb_templatized_alu_issue_ctrl.sv
// Directed bench: main instance at default timeout, second instance with a
// short timeout for the expiry case.
module tb_templatized_alu_issue_ctrl;

    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic            req_valid, req_ready, resp_valid, resp_ready, resp_err, busy;
    logic [2:0]      req_op, unit_en, unit_op, unit_done;
    logic [DW-1:0]   req_a, req_b, unit_a, unit_b, resp_result;
    logic [3*DW-1:0] unit_result;

    logic            t_req_valid, t_req_ready, t_resp_valid, t_resp_ready, t_resp_err, t_busy;
    logic [2:0]      t_req_op, t_unit_en, t_unit_op, t_unit_done;
    logic [DW-1:0]   t_req_a, t_req_b, t_unit_a, t_unit_b, t_resp_result;
    logic [3*DW-1:0] t_unit_result;

    templatized_alu_issue_ctrl #(.DATA_W(DW), .TMO_W(8), .MAX_WAIT(200)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
        .req_a_i(req_a), .req_b_i(req_b),
        .unit_en_o(unit_en), .unit_op_o(unit_op), .unit_a_o(unit_a), .unit_b_o(unit_b),
        .unit_done_i(unit_done), .unit_result_i(unit_result),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
        .resp_result_o(resp_result), .resp_err_o(resp_err), .busy_o(busy)
    );

    templatized_alu_issue_ctrl #(.DATA_W(DW), .TMO_W(8), .MAX_WAIT(4)) dut_t (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(t_req_valid), .req_ready_o(t_req_ready), .req_op_i(t_req_op),
        .req_a_i(t_req_a), .req_b_i(t_req_b),
        .unit_en_o(t_unit_en), .unit_op_o(t_unit_op), .unit_a_o(t_unit_a), .unit_b_o(t_unit_b),
        .unit_done_i(t_unit_done), .unit_result_i(t_unit_result),
        .resp_valid_o(t_resp_valid), .resp_ready_i(t_resp_ready),
        .resp_result_o(t_resp_result), .resp_err_o(t_resp_err), .busy_o(t_busy)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic resp_handshake();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk("idle_ready", req_ready, 1'b1);
        chk("idle_vld", resp_valid, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int en_cnt;
        rst_n = 1'b0;
        req_valid = 0; req_op = 0; req_a = 0; req_b = 0; unit_done = 0; unit_result = 0; resp_ready = 0;
        t_req_valid = 0; t_req_op = 0; t_req_a = 0; t_req_b = 0; t_unit_done = 0; t_unit_result = 0; t_resp_ready = 0;
        tick(); tick();

        chk("rst_ready", req_ready, 1'b1);
        chk("rst_en", unit_en, 3'b000);
        chk("rst_vld", resp_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_res", resp_result, 0);
        chk("rst_err", resp_err, 1'b0);
        chk("rst_t_ready", t_req_ready, 1'b1);
        rst_n = 1'b1;
        tick();

        // 1: unit1, done on first EXEC cycle
        req_valid = 1; req_op = 3'b010; req_a = 5; req_b = 3;
        tick();
        req_valid = 0;
        chk("t1_en", unit_en, 3'b010);
        chk("t1_a", unit_a, 5);
        chk("t1_b", unit_b, 3);
        chk("t1_op", unit_op, 3'b010);
        chk("t1_busy", busy, 1'b1);
        chk("t1_ready", req_ready, 1'b0);
        unit_done = 3'b010;
        unit_result = {32'h0, 32'h8, 32'h0};
        tick();
        unit_done = 0;
        chk("t1_vld", resp_valid, 1'b1);
        chk("t1_res", resp_result, 32'h8);
        chk("t1_err", resp_err, 1'b0);
        chk("t1_en_off", unit_en, 3'b000);
        resp_handshake();

        // 2: unit2, done after 7 EXEC cycles, operands stable
        req_valid = 1; req_op = 3'b101; req_a = 32'h1111; req_b = 32'h2222;
        unit_result = {32'h0, 32'h0, 32'hDEAD};
        tick();
        req_valid = 0; req_a = 32'hFFFF; req_b = 32'h0;
        en_cnt = 0;
        for (int i = 0; i < 7; i++) begin
            if (unit_en == 3'b001) en_cnt++;
            chk("t2_a", unit_a, 32'h1111);
            chk("t2_b", unit_b, 32'h2222);
            chk("t2_novld", resp_valid, 1'b0);
            unit_done = (i == 6) ? 3'b001 : 3'b000;
            tick();
        end
        unit_done = 0;
        chk("t2_encnt", en_cnt, 7);
        chk("t2_vld", resp_valid, 1'b1);
        chk("t2_res", resp_result, 32'hDEAD);
        chk("t2_err", resp_err, 1'b0);
        resp_handshake();

        // 3: illegal op
        req_valid = 1; req_op = 3'b111; req_a = 1; req_b = 2;
        tick();
        req_valid = 0;
        chk("t3_vld", resp_valid, 1'b1);
        chk("t3_err", resp_err, 1'b1);
        chk("t3_res", resp_result, 0);
        chk("t3_en", unit_en, 3'b000);
        resp_handshake();

        // 4: timeout on short-timeout instance
        t_req_valid = 1; t_req_op = 3'b000; t_req_a = 9;
        tick();
        t_req_valid = 0;
        for (int i = 0; i < 4; i++) begin
            chk("t4_en", t_unit_en, 3'b100);
            chk("t4_novld", t_resp_valid, 1'b0);
            tick();
        end
        chk("t4_vld", t_resp_valid, 1'b1);
        chk("t4_err", t_resp_err, 1'b1);
        chk("t4_res", t_resp_result, 0);
        chk("t4_en_off", t_unit_en, 3'b000);
        t_unit_done = 3'b100;
        t_unit_result = {32'h55, 32'h0, 32'h0};
        tick();
        chk("t4_late_res", t_resp_result, 0);
        chk("t4_late_err", t_resp_err, 1'b1);
        t_resp_ready = 1;
        tick();
        t_resp_ready = 0;
        chk("t4_idle", t_req_ready, 1'b1);
        chk("t4_idle_vld", t_resp_valid, 1'b0);
        tick();
        chk("t4_late_en", t_unit_en, 3'b000);
        chk("t4_late_busy", t_busy, 1'b0);
        t_unit_done = 0;

        // 5: unit0 with foreign done pulses, response back-pressured
        req_valid = 1; req_op = 3'b001; req_a = 3; req_b = 4;
        unit_result = {32'hA0A0, 32'hB1B1, 32'hC2C2};
        tick();
        req_valid = 0;
        chk("t5_en", unit_en, 3'b100);
        unit_done = 3'b011;
        tick();
        chk("t5_ign1", resp_valid, 1'b0);
        chk("t5_en2", unit_en, 3'b100);
        unit_done = 3'b001;
        tick();
        chk("t5_ign2", resp_valid, 1'b0);
        unit_done = 3'b100;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("t5_vld", resp_valid, 1'b1);
            chk("t5_res", resp_result, 32'hA0A0);
            chk("t5_err", resp_err, 1'b0);
            chk("t5_ready", req_ready, 1'b0);
            unit_done = 3'b111;
            unit_result = {32'h1234, 32'h5678, 32'h9ABC};
            tick();
        end
        resp_handshake();
        unit_done = 0;

        // 6: reset mid-EXEC, then a normal op
        req_valid = 1; req_op = 3'b011; req_a = 7; req_b = 8;
        tick();
        req_valid = 0;
        chk("t6_en", unit_en, 3'b001);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_en", unit_en, 3'b000);
        chk("t6_rst_vld", resp_valid, 1'b0);
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_ready", req_ready, 1'b1);
        chk("t6_rst_a", unit_a, 0);
        chk("t6_rst_op", unit_op, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_no_resp", resp_valid, 1'b0);
        req_valid = 1; req_op = 3'b100; req_a = 1; req_b = 1;
        unit_result = {32'h0, 32'h0, 32'h77};
        tick();
        req_valid = 0;
        chk("t6_en2", unit_en, 3'b001);
        unit_done = 3'b001;
        tick();
        unit_done = 0;
        chk("t6_vld", resp_valid, 1'b1);
        chk("t6_res", resp_result, 32'h77);
        chk("t6_err", resp_err, 1'b0);
        resp_handshake();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
